inst_sram_resp: RTL and testbench
=================================

INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h1c00_0000, meaning the byte address of word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of the word count (4096 x 32-bit).
REQ-003 SHALL have parameter OOR_DATA, default 32'h0340_0000 (nop), meaning read data returned for out-of-range accesses.
REQ-004 SHALL have port clk  input  1  the only clock, rising edge.
REQ-005 SHALL have port resetn  input  1  reset; one clock; reset is synchronous and active-low.
REQ-006 SHALL have port inst_sram_en  input  1  bus access request this cycle.
REQ-007 SHALL have port inst_sram_wen  input  4  byte write enables; bit i covers data bits [8i+7:8i]; 0 means read.
REQ-008 SHALL have port inst_sram_addr  input  32  byte address.
REQ-009 SHALL have port inst_sram_wdata  input  32  write data.
REQ-010 SHALL have port inst_sram_rdata  output  32  registered read data.
REQ-011 SHALL have port ld_en  input  1  loader write strobe (memory preload).
REQ-012 SHALL have port ld_addr  input  DEPTH_LOG2  loader word index.
REQ-013 SHALL have port ld_data  input  32  loader write word, full-word write.
REQ-014 SHALL have port oor_err  output  1  sticky out-of-range access flag.
REQ-015 SHALL have port rd_cnt  output  32  count of accepted bus reads.
REQ-016 SHALL have port wr_cnt  output  32  count of accepted bus writes.

Function
REQ-017 SHALL accept a bus access in a cycle only if resetn=1, inst_sram_en=1 and ld_en=0.
REQ-018 SHALL treat an access as in range iff (addr - ADDR_BASE), unsigned 32-bit, is < 4*2^DEPTH_LOG2; word index = bits [DEPTH_LOG2+1:2] of that offset; addr[1:0] ignored.
REQ-019 SHALL, for an accepted in-range read (wen=0), present mem[index] on inst_sram_rdata from the next rising edge (1-cycle latency).
REQ-020 SHALL, for an accepted in-range write (wen!=0), update only the enabled bytes of mem[index] at the edge and present the merged new word on inst_sram_rdata next cycle (write-first).
REQ-021 SHALL, for any accepted out-of-range access, leave memory unchanged, load OOR_DATA into inst_sram_rdata, and set oor_err at the same edge.
REQ-022 SHALL hold inst_sram_rdata unchanged in every cycle with no accepted access (en=0, or ld_en=1), so the initiator may stall any number of cycles and still sample the last fetched word.
REQ-023 SHALL, when ld_en=1 and resetn=1, write ld_data to mem[ld_addr] at the edge; the loader has priority and the concurrent bus access is dropped (no memory effect, no rdata change, no counter change, no oor_err update).
REQ-024 SHALL increment rd_cnt by 1 on each accepted read and wr_cnt by 1 on each accepted write, in or out of range, wrapping 32'hffff_ffff -> 0.
REQ-025 SHALL keep oor_err at 1 once set until reset.
REQ-026 SHALL accept back-to-back accesses every cycle with no bubble; consecutive reads to A then B yield mem[A] then mem[B] on consecutive cycles.
REQ-027 SHALL make a read in the cycle after a write to the same word return the written value.

Reset
REQ-028 SHALL, on a rising edge with resetn=0, set inst_sram_rdata=32'h0, oor_err=0, rd_cnt=0, wr_cnt=0.
REQ-029 SHALL ignore bus and loader activity in any reset cycle; memory contents SHALL NOT be cleared by reset and survive a reset asserted mid-sequence.
REQ-030 SHALL accept the first access in the first cycle with resetn=1.

Verification
REQ-031 SHALL cover preload: ld writes 32'h0280_0421 to index 0, then read addr 32'h1c00_0000 -> rdata 32'h0280_0421 one cycle later, rd_cnt=1.
REQ-032 SHALL cover stall hold: read 32'h1c00_0004 (mem=32'h1111_2222), then en=0 for 5 cycles -> rdata stays 32'h1111_2222 all 5 cycles, rd_cnt unchanged.
REQ-033 SHALL cover byte write: mem[2]=32'haabb_ccdd, write addr 32'h1c00_0008 wen=4'b0101 wdata 32'h1122_3344 -> next-cycle rdata 32'haa22_cc44, wr_cnt=1, subsequent read returns same.
REQ-034 SHALL cover out-of-range: read addr 32'h1bff_fffc -> rdata 32'h0340_0000, oor_err=1 and remains 1 after later in-range accesses; write to 32'h1c00_4000 leaves memory unchanged.
REQ-035 SHALL cover loader priority: ld_en=1 with bus write to the same index -> memory holds ld_data, rdata and wr_cnt unchanged.
REQ-036 SHALL cover reset mid-run: after accesses, resetn=0 for 1 cycle -> rdata=0, counters=0, oor_err=0; then reading a previously written word returns its pre-reset value.

Source files
------------

// File: rtl/inst_sram_resp_if.sv
// Instruction SRAM bus bundle: request (en/wen/addr/wdata) and registered read data.
// Latency: none; this file is wiring only.
// Backpressure: none; the bus is always ready and the initiator stalls by dropping en.
// Ports: master drives the request and samples rdata; slave samples the request and drives rdata.
interface inst_sram_resp_if;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;

   modport master (
      output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      input  inst_sram_rdata
   );

   modport slave (
      input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
      output inst_sram_rdata
   );
endinterface

// File: rtl/inst_sram_resp.sv
// Single-port instruction SRAM with byte writes, preload port, range check and access counters.
// Latency: 1 cycle from an accepted access to inst_sram_rdata (write-first on writes).
// Backpressure: none; accepts an access every cycle, rdata holds while no access is accepted.
// Ports: clk/resetn (sync, active-low); bus = slave side of inst_sram_resp_if;
//        ld_en/ld_addr/ld_data = full-word preload writes (win over the bus);
//        oor_err = sticky out-of-range flag; rd_cnt/wr_cnt = accepted read/write counts.
module inst_sram_resp #(
   parameter logic [31:0] ADDR_BASE  = 32'h1c00_0000,
   parameter int          DEPTH_LOG2 = 12,
   parameter logic [31:0] OOR_DATA   = 32'h0340_0000
) (
   input  logic                  clk,
   input  logic                  resetn,
   inst_sram_resp_if.slave       bus,
   input  logic                  ld_en,
   input  logic [DEPTH_LOG2-1:0] ld_addr,
   input  logic [31:0]           ld_data,
   output logic                  oor_err,
   output logic [31:0]           rd_cnt,
   output logic [31:0]           wr_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   // Size of the mapped window in bytes; one extra bit so DEPTH_LOG2 up to 30 still fits.
   localparam logic [32:0] SPAN = 33'd1 << (DEPTH_LOG2 + 2);

   logic [31:0] mem [0:DEPTH-1];

   logic [31:0]           off;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  acc;
   logic                  is_wr;
   logic                  mem_we;
   logic [31:0]           merged;

   logic [31:0] rdata_q, rdata_d;
   logic        oor_q, oor_d;
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;

   // Unsigned wrap makes addresses below the base land far above the window.
   assign off      = bus.inst_sram_addr - ADDR_BASE;
   assign in_range = ({1'b0, off} < SPAN);
   assign idx      = off[DEPTH_LOG2+1:2];
   assign acc      = resetn & bus.inst_sram_en & ~ld_en;
   assign is_wr    = |bus.inst_sram_wen;
   assign mem_we   = acc & in_range & is_wr;

   // Merged word doubles as read data: with wen=0 it is simply mem[idx].
   always_comb begin
      merged = mem[idx];
      for (int b = 0; b < 4; b++) begin
         if (bus.inst_sram_wen[b]) begin
            merged[8*b +: 8] = bus.inst_sram_wdata[8*b +: 8];
         end
      end
   end

   // Memory has no reset so contents survive a reset pulse; one write per cycle, loader first.
   always_ff @(posedge clk) begin
      if (resetn && ld_en) begin
         mem[ld_addr] <= ld_data;
      end else if (mem_we) begin
         mem[idx] <= merged;
      end
   end

   always_comb begin
      rdata_d  = rdata_q;
      oor_d    = oor_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (acc) begin
         if (in_range) begin
            rdata_d = merged;
         end else begin
            rdata_d = OOR_DATA;
            oor_d   = 1'b1;
         end
         if (is_wr) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
         end else begin
            rd_cnt_d = rd_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rdata_q  <= 32'h0;
         oor_q    <= 1'b0;
         rd_cnt_q <= 32'h0;
         wr_cnt_q <= 32'h0;
      end else begin
         rdata_q  <= rdata_d;
         oor_q    <= oor_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign bus.inst_sram_rdata = rdata_q;
   assign oor_err             = oor_q;
   assign rd_cnt              = rd_cnt_q;
   assign wr_cnt              = wr_cnt_q;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Bench for inst_sram_resp: directed scenarios plus random traffic against an array model.
// Latency: model result is compared 1 ns after each rising edge.
// Backpressure: none; stimulus may issue an access every cycle.
module tb_inst_sram_resp;

   localparam logic [31:0] BASE  = 32'h1c00_0000;
   localparam logic [31:0] OOR   = 32'h0340_0000;
   localparam int          WORDS = 4096;
   localparam logic [31:0] BYTES = 32'd16384;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ld_en;
   logic [11:0] ld_addr;
   logic [31:0] ld_data;
   logic        oor_err;
   logic [31:0] rd_cnt;
   logic [31:0] wr_cnt;

   inst_sram_resp_if bus_if ();

   inst_sram_resp dut (
      .clk     (clk),
      .resetn  (resetn),
      .bus     (bus_if),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .oor_err (oor_err),
      .rd_cnt  (rd_cnt),
      .wr_cnt  (wr_cnt)
   );

   always #5 clk = ~clk;

   // Reference state
   logic [31:0] m_mem [0:WORDS-1];
   logic [31:0] m_rdata;
   logic        m_oor;
   logic [31:0] m_rd;
   logic [31:0] m_wr;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: apply inputs, advance the model by the behavioural rules, compare.
   task automatic cyc(input logic rn, input logic en, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic le, input logic [11:0] la, input logic [31:0] ld);
      logic [31:0] offs;
      int          w;
      resetn                 = rn;
      bus_if.inst_sram_en    = en;
      bus_if.inst_sram_wen   = wen;
      bus_if.inst_sram_addr  = addr;
      bus_if.inst_sram_wdata = wdata;
      ld_en                  = le;
      ld_addr                = la;
      ld_data                = ld;
      @(posedge clk);
      if (!rn) begin
         m_rdata = 32'h0;
         m_oor   = 1'b0;
         m_rd    = 32'h0;
         m_wr    = 32'h0;
      end else if (le) begin
         m_mem[la] = ld;
      end else if (en) begin
         offs = addr - BASE;
         if (offs < BYTES) begin
            w = int'(offs / 4);
            for (int b = 0; b < 4; b++)
               if (wen[b]) m_mem[w][8*b +: 8] = wdata[8*b +: 8];
            m_rdata = m_mem[w];
         end else begin
            m_rdata = OOR;
            m_oor   = 1'b1;
         end
         if (wen == 4'h0) m_rd = m_rd + 1;
         else             m_wr = m_wr + 1;
      end
      #1;
      chk("rdata",   bus_if.inst_sram_rdata, m_rdata);
      chk("oor_err", {31'h0, oor_err},       {31'h0, m_oor});
      chk("rd_cnt",  rd_cnt,                 m_rd);
      chk("wr_cnt",  wr_cnt,                 m_wr);
   endtask

   task automatic idle();
      cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 12'h0, 32'h0);
   endtask

   task automatic rd(input logic [31:0] a);
      cyc(1'b1, 1'b1, 4'h0, a, $urandom, 1'b0, 12'h0, 32'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      cyc(1'b1, 1'b1, be, a, d, 1'b0, 12'h0, 32'h0);
   endtask

   task automatic load(input logic [11:0] i, input logic [31:0] d);
      cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, i, d);
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] lo;
      lo = 32'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
         0:       return BASE + 32'($urandom_range(0, 31)) * 4 + lo;
         1:       return BASE + BYTES - 32'($urandom_range(0, 7)) * 4 + lo;
         2:       return BASE - 32'($urandom_range(1, 4)) * 4 + lo;
         3:       return BASE + BYTES + 32'($urandom_range(0, 7)) * 4 + lo;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] held;
      m_rdata = 32'h0; m_oor = 1'b0; m_rd = 32'h0; m_wr = 32'h0;
      resetn = 1'b0; ld_en = 1'b0; ld_addr = 12'h0; ld_data = 32'h0;
      bus_if.inst_sram_en = 1'b0; bus_if.inst_sram_wen = 4'h0;
      bus_if.inst_sram_addr = 32'h0; bus_if.inst_sram_wdata = 32'h0;
      @(negedge clk);

      // Reset with bus activity present: must be ignored.
      cyc(1'b0, 1'b1, 4'hf, BASE, 32'hffff_ffff, 1'b0, 12'h0, 32'h0);
      chk("reset_rdata", bus_if.inst_sram_rdata, 32'h0);

      // Preload every word so reads never see uninitialised storage.
      for (int i = 0; i < WORDS; i++) load(12'(i), $urandom);

      // Preload then read word 0.
      load(12'd0, 32'h0280_0421);
      rd(32'h1c00_0000);
      chk("preload_rdata", bus_if.inst_sram_rdata, 32'h0280_0421);
      chk("preload_rdcnt", rd_cnt, 32'd1);

      // Stall hold for 5 cycles.
      load(12'd1, 32'h1111_2222);
      rd(32'h1c00_0004);
      for (int i = 0; i < 5; i++) begin
         idle();
         chk("stall_rdata", bus_if.inst_sram_rdata, 32'h1111_2222);
         chk("stall_rdcnt", rd_cnt, 32'd2);
      end

      // Byte write, write-first return, then read back.
      load(12'd2, 32'haabb_ccdd);
      wr(32'h1c00_0008, 4'b0101, 32'h1122_3344);
      chk("bytewr_rdata", bus_if.inst_sram_rdata, 32'haa22_cc44);
      chk("bytewr_wrcnt", wr_cnt, 32'd1);
      rd(32'h1c00_0008);
      chk("bytewr_readback", bus_if.inst_sram_rdata, 32'haa22_cc44);

      // Out of range below base, sticky flag, write above window.
      rd(32'h1bff_fffc);
      chk("oor_rdata", bus_if.inst_sram_rdata, OOR);
      chk("oor_flag", {31'h0, oor_err}, 32'd1);
      rd(32'h1c00_0004);
      wr(32'h1c00_4000, 4'hf, 32'hdead_0000);
      rd(32'h1c00_0000);
      chk("oor_nowrite", bus_if.inst_sram_rdata, 32'h0280_0421);
      chk("oor_sticky", {31'h0, oor_err}, 32'd1);

      // Loader wins over a concurrent bus write to the same word.
      held = bus_if.inst_sram_rdata;
      cyc(1'b1, 1'b1, 4'hf, 32'h1c00_000c, 32'h1234_5678, 1'b1, 12'd3, 32'hdead_beef);
      chk("ldprio_rdata", bus_if.inst_sram_rdata, held);
      chk("ldprio_wrcnt", wr_cnt, 32'd2);
      rd(32'h1c00_000c);
      chk("ldprio_mem", bus_if.inst_sram_rdata, 32'hdead_beef);

      // Mid-run reset, with loader and bus activity that must be dropped.
      cyc(1'b0, 1'b1, 4'hf, 32'h1c00_0008, 32'h0, 1'b1, 12'd2, 32'h0);
      chk("rst_rdata", bus_if.inst_sram_rdata, 32'h0);
      chk("rst_rdcnt", rd_cnt, 32'h0);
      chk("rst_wrcnt", wr_cnt, 32'h0);
      chk("rst_oor", {31'h0, oor_err}, 32'h0);
      rd(32'h1c00_0008);
      chk("rst_survive", bus_if.inst_sram_rdata, 32'haa22_cc44);

      // Back-to-back reads to distinct words.
      rd(32'h1c00_0004);
      chk("b2b_a", bus_if.inst_sram_rdata, 32'h1111_2222);
      rd(32'h1c00_000c);
      chk("b2b_b", bus_if.inst_sram_rdata, 32'hdead_beef);

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         logic rn, en, le;
         logic [3:0] wen;
         rn  = ($urandom_range(0, 63) != 0);
         en  = ($urandom_range(0, 3) != 0);
         le  = ($urandom_range(0, 7) == 0);
         wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         cyc(rn, en, wen, rnd_addr(), $urandom, le,
             ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 31)) : 12'($urandom),
             $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
